// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier slice: FSM state
// encoding, the default operand width and a counter-width helper.
package mult_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Width of the iteration counter; never narrower than one bit.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Operand and product handshake bundle for shift_add_multiplier.
//
// Handshake rules (both channels): a transfer happens on a rising clk edge
// where valid && ready are both high. The producer holds valid and its data
// stable until that edge; ready may rise and fall freely and never depends
// combinationally on valid. Operand channel: in_valid/in_a/in_b from the
// source, in_ready from the multiplier. Product channel: out_valid/
// out_product from the multiplier, out_ready from the consumer.
interface shift_add_multiplier_if #(
   parameter int WIDTH = mult_pkg::DEFAULT_WIDTH
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_a;
   logic [WIDTH-1:0]     in_b;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   out_product;

   // Operand source and product consumer side.
   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_product
   );

   // Multiplier side.
   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_product
   );
endinterface

// File: rtl/shift_add_datapath.sv
// M/A/Q register file of the shift-add multiplier plus the operand muxes
// feeding the external adder. The adder result is folded back one bit to
// the right each shift cycle, so {A,Q} ends up holding the full product.
module shift_add_datapath
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 zero_load,
   input  logic                 shift,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic [WIDTH-1:0]     add_sum,
   input  logic                 add_cout,
   output logic [WIDTH-1:0]     add_a,
   output logic [WIDTH-1:0]     add_b,
   output logic [2*WIDTH-1:0]   acc
);

   logic [WIDTH-1:0] m;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] q;

   // Operand load on accept; one add-and-shift step per BUSY cycle.
   // The adder carry-out becomes the new MSB of A so no product bit is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m <= '0;
         a <= '0;
         q <= '0;
      end else if (load) begin
         m <= zero_load ? '0 : in_a;
         q <= zero_load ? '0 : in_b;
         a <= '0;
      end else if (shift) begin
         a <= {add_cout, add_sum[WIDTH-1:1]};
         q <= {add_sum[0], q[WIDTH-1:1]};
      end
   end

   // Adder operands are parked at zero outside the shift phase.
   always_comb begin
      add_a = '0;
      add_b = '0;
      if (shift) begin
         add_a = a;
         add_b = q[0] ? m : '0;
      end
   end

   assign acc = {a, q};

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier driving an external
// ripple-carry adder. Control FSM (IDLE -> BUSY -> DONE) and the iteration
// counter live here; registers and adder muxes live in shift_add_datapath.
// Optional feature macro: ZERO_SKIP_EN -- when defined, a zero operand
// skips the BUSY phase and the product (0) is presented one cycle after
// accept. Default build runs every multiply for the full WIDTH cycles.
module shift_add_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   shift_add_multiplier_if.slave   bus,
   output logic [WIDTH-1:0]        add_a,
   output logic [WIDTH-1:0]        add_b,
   output logic                    add_cin,
   input  logic [WIDTH-1:0]        add_sum,
   input  logic                    add_cout,
   output logic                    busy,
   output state_t                  state_dbg
);

   localparam int              CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t               state;
   state_t               state_nx;
   logic [CNT_W-1:0]     cnt;
   logic                 load;
   logic                 zero_load;
   logic                 shift;
   logic                 operand_zero;
   logic [2*WIDTH-1:0]   acc;

   assign add_cin      = 1'b0;
   assign operand_zero = (bus.in_a == '0) || (bus.in_b == '0);
   assign state_dbg    = state;

   // State register; reset aborts any multiply in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and Moore-style control outputs.
   always_comb begin
      state_nx      = state;
      load          = 1'b0;
      zero_load     = 1'b0;
      shift         = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      busy          = 1'b0;
      case (state)
         ST_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               load = 1'b1;
`ifdef ZERO_SKIP_EN
               if (operand_zero) begin
                  zero_load = 1'b1;
                  state_nx  = ST_DONE;
               end else begin
                  state_nx  = ST_BUSY;
               end
`else
               state_nx = ST_BUSY;
`endif
            end
         end
         ST_BUSY: begin
            shift = 1'b1;
            busy  = 1'b1;
            if (cnt == CNT_LAST) begin
               state_nx = ST_DONE;
            end
         end
         ST_DONE: begin
            bus.out_valid = 1'b1;
            busy          = 1'b1;
            if (bus.out_ready) begin
               state_nx = ST_IDLE;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Iteration counter: cleared on accept, stepped once per BUSY cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (shift) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Product is only presented while DONE, otherwise held at zero.
   always_comb begin
      bus.out_product = '0;
      if (state == ST_DONE) begin
         bus.out_product = acc;
      end
   end

   shift_add_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .zero_load (zero_load),
      .shift     (shift),
      .in_a      (bus.in_a),
      .in_b      (bus.in_b),
      .add_sum   (add_sum),
      .add_cout  (add_cout),
      .add_a     (add_a),
      .add_b     (add_b),
      .acc       (acc)
   );

   // The unused-operand flag only feeds logic in the zero-skip build.
   logic unused_ok;
   assign unused_ok = operand_zero;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier (WIDTH=4) with a behavioural
// ripple-carry adder closing the loop. Expected products and latencies
// are hand-computed constants.
module tb_shift_add_multiplier;
   import mult_pkg::*;

   localparam int W = 4;

`ifdef ZERO_SKIP_EN
   localparam int ZERO_LAT = 1;
`else
   localparam int ZERO_LAT = 5;
`endif

   logic          clk;
   logic          rst_n;
   logic [W-1:0]  add_a;
   logic [W-1:0]  add_b;
   logic          add_cin;
   logic [W-1:0]  add_sum;
   logic          add_cout;
   logic          busy;
   state_t        state_dbg;

   int checks;
   int failures;

   shift_add_multiplier_if #(.WIDTH(W)) bus ();

   shift_add_multiplier #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_sum   (add_sum),
      .add_cout  (add_cout),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   // External combinational adder.
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present operands and hold them until the accept edge.
   task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b);
      int guard;
      guard = 0;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      while (!bus.in_ready && guard < 64) begin
         tick();
         guard++;
      end
      tick();
      bus.in_valid = 1'b0;
   endtask

   // Edges from accept (the accept edge counts as 1) until out_valid.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!bus.out_valid && lat < 64) begin
         tick();
         lat++;
      end
   endtask

   task automatic take_result();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin
         failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
      end
      checks++;
      if (bus.out_product !== 8'h00) begin
         failures++; $display("FAIL reset_out_product got=%h exp=00", bus.out_product);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL reset_busy got=%b exp=0", busy);
      end
      checks++;
      if (state_dbg !== ST_IDLE) begin
         failures++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, ST_IDLE);
      end
      checks++;
      if (add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin
         failures++; $display("FAIL reset_adder_ops got=%h/%h/%b exp=0/0/0", add_a, add_b, add_cin);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_full_scale();
      int lat;
      send_op(4'd15, 4'd15);
      checks++;
      if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
         failures++; $display("FAIL full_busy_flags got ready=%b busy=%b exp ready=0 busy=1", bus.in_ready, busy);
      end
      wait_valid(lat);
      checks++;
      if (lat !== 5) begin
         failures++; $display("FAIL full_latency got=%0d exp=5", lat);
      end
      checks++;
      if (bus.out_product !== 8'hE1) begin
         failures++; $display("FAIL full_product got=%h exp=e1", bus.out_product);
      end
      take_result();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL full_release got valid=%b ready=%b busy=%b exp 0/1/0", bus.out_valid, bus.in_ready, busy);
      end
   endtask

   task automatic test_stall();
      int lat;
      send_op(4'd13, 4'd11);
      wait_valid(lat);
      checks++;
      if (lat !== 5) begin
         failures++; $display("FAIL stall_latency got=%0d exp=5", lat);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_product !== 8'h8F || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold cyc=%0d got valid=%b prod=%h ready=%b exp 1/8f/0", i, bus.out_valid, bus.out_product, bus.in_ready);
         end
         tick();
      end
      checks++;
      if (bus.out_product !== 8'h8F) begin
         failures++; $display("FAIL stall_final got=%h exp=8f", bus.out_product);
      end
      take_result();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         failures++; $display("FAIL stall_release got=%b exp=0", bus.out_valid);
      end
   endtask

   task automatic test_zero();
      int lat;
      send_op(4'd0, 4'd9);
      wait_valid(lat);
      checks++;
      if (lat !== ZERO_LAT) begin
         failures++; $display("FAIL zero_latency got=%0d exp=%0d", lat, ZERO_LAT);
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_product !== 8'h00) begin
         failures++; $display("FAIL zero_product got valid=%b prod=%h exp 1/00", bus.out_valid, bus.out_product);
      end
      take_result();
   endtask

   task automatic test_abort();
      int lat;
      send_op(4'd15, 4'd15);
      tick();
      checks++;
      if (state_dbg !== ST_BUSY) begin
         failures++; $display("FAIL abort_pre_state got=%0d exp=%0d", state_dbg, ST_BUSY);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_product !== 8'h00) begin
         failures++;
         $display("FAIL abort_outputs got valid=%b busy=%b ready=%b prod=%h exp 0/0/1/00", bus.out_valid, busy, bus.in_ready, bus.out_product);
      end
      #1;
      rst_n = 1'b1;
      tick();
      send_op(4'd3, 4'd5);
      wait_valid(lat);
      checks++;
      if (lat !== 5 || bus.out_product !== 8'h0F) begin
         failures++; $display("FAIL abort_after got lat=%0d prod=%h exp 5/0f", lat, bus.out_product);
      end
      take_result();
   endtask

   task automatic test_back_to_back();
      int lat;
      send_op(4'd2, 4'd3);
      bus.in_valid = 1'b1;
      bus.in_a     = 4'd7;
      bus.in_b     = 4'd6;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         failures++; $display("FAIL b2b_ready_busy got=%b exp=0", bus.in_ready);
      end
      wait_valid(lat);
      checks++;
      if (lat !== 5 || bus.out_product !== 8'h06) begin
         failures++; $display("FAIL b2b_first got lat=%0d prod=%h exp 5/06", lat, bus.out_product);
      end
      take_result();
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         failures++; $display("FAIL b2b_idle got ready=%b valid=%b exp 1/0", bus.in_ready, bus.out_valid);
      end
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if (state_dbg !== ST_BUSY) begin
         failures++; $display("FAIL b2b_accept_state got=%0d exp=%0d", state_dbg, ST_BUSY);
      end
      wait_valid(lat);
      checks++;
      if (lat !== 5 || bus.out_product !== 8'h2A) begin
         failures++; $display("FAIL b2b_second got lat=%0d prod=%h exp 5/2a", lat, bus.out_product);
      end
      take_result();
   endtask

   task automatic test_mid_value();
      int lat;
      send_op(4'd9, 4'd14);
      wait_valid(lat);
      checks++;
      if (lat !== 5 || bus.out_product !== 8'h7E) begin
         failures++; $display("FAIL mid_product got lat=%0d prod=%h exp 5/7e", lat, bus.out_product);
      end
      take_result();
   endtask

   // Sequencer and final report.
   initial begin
      checks        = 0;
      failures      = 0;
      rst_n         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_full_scale();
      test_stall();
      test_zero();
      test_abort();
      test_back_to_back();
      test_mid_value();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
